coin_acceptor: RTL and testbench

//  Upstream stage of the vending FSM: turns raw, bouncy coin-slot sensor lines into clean
//  one-cycle coin codes on the FSM's 3-bit coin input. Synchronises and debounces the sensors.

---
 rtl/coin_acceptor.sv | 147 ++++++++++++++
 tb/tb_coin_acceptor.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the three coin sensors, rejects
// multi-sensor hits and queues accepted coin codes in a show-ahead FIFO for the vending FSM.
`timescale 1ns/1ps
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [2:0]                  coin_sense,
   input  logic                        coin_rdy,
   output logic [2:0]                  coin_out,
   output logic                        coin_valid,
   output logic                        coin_reject,
   output logic                        coin_drop,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int AW1 = AW + 1;
   localparam int CW  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [AW:0]    FULL_CNT = AW1'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_SETTLE   = 2'd1;
   localparam logic [1:0] S_WAIT_REL = 2'd2;

   logic [2:0]    r_sync_p0;
   logic [2:0]    r_sync_p1;
   logic [1:0]    r_state;
   logic [2:0]    r_pat;
   logic [CW-1:0] r_cnt;
   logic          r_reject;
   logic          r_drop;
   logic [2:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wp;
   logic [AW:0]   r_rp;

   logic          w_settle;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_wr;
   logic [AW:0]   w_count;

   function automatic logic is_onehot(input logic [2:0] p);
      return (p == 3'b001) || (p == 3'b010) || (p == 3'b100);
   endfunction

   function automatic logic [2:0] coin_code(input logic [2:0] p);
      case (p)
         3'b001:  return 3'd1;
         3'b010:  return 3'd2;
         default: return 3'd5;
      endcase
   endfunction

   // Stage p0/p1: two-flop synchroniser on the raw sensor lines
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_p0 <= 3'd0;
         r_sync_p1 <= 3'd0;
      end else begin
         r_sync_p0 <= coin_sense;
         r_sync_p1 <= r_sync_p0;
      end
   end

   // Debounce FSM; reset lands in WAIT_REL so a sensor held through reset is never counted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_WAIT_REL;
         r_pat   <= 3'd0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_sync_p1 != 3'd0) begin
                  r_pat   <= r_sync_p1;
                  r_cnt   <= CNT_ONE;
                  r_state <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (r_sync_p1 == 3'd0) begin
                  r_state <= S_IDLE;
               end else if (r_sync_p1 != r_pat) begin
                  r_pat <= r_sync_p1;
                  r_cnt <= CNT_ONE;
               end else if (r_cnt < CNT_LAST) begin
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_state <= S_WAIT_REL;
                  r_cnt   <= '0;
               end
            end
            S_WAIT_REL: begin
               if (r_sync_p1 != 3'd0) begin
                  r_cnt <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_WAIT_REL;
         endcase
      end
   end

   assign w_settle = (r_state == S_SETTLE) && (r_sync_p1 != 3'd0) &&
                     (r_sync_p1 == r_pat) && (r_cnt == CNT_LAST);
   assign w_push   = w_settle && is_onehot(r_pat);

   // Show-ahead FIFO: pointers carry an extra wrap bit so full and empty are distinguishable
   assign w_count  = r_wp - r_rp;
   assign w_full   = (w_count == FULL_CNT);
   assign w_pop    = coin_valid && coin_rdy;
   assign w_wr     = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp     <= '0;
         r_rp     <= '0;
         r_reject <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         if (w_wr)  r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_reject <= w_settle && !is_onehot(r_pat);
         r_drop   <= w_push && !w_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp[AW-1:0]] <= coin_code(r_pat);
   end

   assign coin_valid  = (r_wp != r_rp);
   assign coin_out    = coin_valid ? r_mem[r_rp[AW-1:0]] : 3'd0;
   assign coin_reject = r_reject;
   assign coin_drop   = r_drop;
   assign fifo_count  = w_count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random sensor traffic, every cycle
// compared against a run-length reference model of the debounce rules and a queue FIFO.
`timescale 1ns/1ps
module tb_coin_acceptor;
   localparam int D     = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] coin_sense = 3'd0;
   logic       coin_rdy = 1'b0;
   logic [2:0] coin_out;
   logic       coin_valid;
   logic       coin_reject;
   logic       coin_drop;
   logic [2:0] fifo_count;

   int n_cmp  = 0;
   int n_fail = 0;

   coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .coin_sense(coin_sense), .coin_rdy(coin_rdy),
      .coin_out(coin_out), .coin_valid(coin_valid), .coin_reject(coin_reject),
      .coin_drop(coin_drop), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Reference model: a coin fires on D identical nonzero samples while armed,
   // and the slot re-arms after D consecutive zero samples.
   int         m_q[$];
   logic [2:0] m_d1 = 3'd0, m_d2 = 3'd0, m_last = 3'd0;
   bit         m_armed = 1'b0;
   int         m_run = 0, m_zrun = 0;
   bit         m_rej = 1'b0, m_drop = 1'b0;

   function automatic int code_of(input logic [2:0] p);
      case (p)
         3'b001:  return 1;
         3'b010:  return 2;
         3'b100:  return 5;
         default: return 0;
      endcase
   endfunction

   task automatic model_edge();
      logic [2:0] s;
      bit fire, pop;
      int sz;
      if (rst) begin
         m_q.delete();
         m_d1 = 3'd0; m_d2 = 3'd0; m_last = 3'd0;
         m_armed = 1'b0; m_run = 0; m_zrun = 0; m_rej = 1'b0; m_drop = 1'b0;
         return;
      end
      s = m_d2; m_d2 = m_d1; m_d1 = coin_sense;
      fire = 1'b0;
      if (m_armed) begin
         if (s == 3'd0) m_run = 0;
         else if (s == m_last) m_run++;
         else m_run = 1;
         if (m_run == D) begin fire = 1'b1; m_armed = 1'b0; m_zrun = 0; end
      end else begin
         if (s == 3'd0) m_zrun++; else m_zrun = 0;
         if (m_zrun == D) begin m_armed = 1'b1; m_run = 0; end
      end
      m_last = s;
      sz  = m_q.size();
      pop = (sz > 0) && coin_rdy;
      m_rej  = fire && (code_of(s) == 0);
      m_drop = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (fire && code_of(s) != 0) begin
         if (sz < DEPTH || pop) m_q.push_back(code_of(s));
         else m_drop = 1'b1;
      end
   endtask

   function automatic logic [8:0] exp_vec();
      logic [2:0] head;
      head = (m_q.size() > 0) ? 3'(m_q[0]) : 3'd0;
      return {m_q.size() > 0, head, 3'(m_q.size()), m_rej, m_drop};
   endfunction

   wire [8:0] w_dut = {coin_valid, coin_out, fifo_count, coin_reject, coin_drop};

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; coin_sense = 3'b101; coin_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (w_dut !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", w_dut, 9'd0);
         end
      end
      rst = 1'b0; coin_sense = 3'd0;
      for (int i = 0; i < 8; i++) begin
         step();
         n_cmp++;
         if (w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", w_dut, exp_vec());
         end
      end
   endtask

   task automatic test_single();
      int rise = 0, pulses = 0;
      coin_rdy = 1'b1; coin_sense = 3'b001;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 10) coin_sense = 3'd0;
         n_cmp++;
         if (w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_cycle%0d: got %b want %b", i, w_dut, exp_vec());
         end
         if (coin_valid) begin
            pulses++;
            if (rise == 0) rise = i;
         end
      end
      n_cmp++;
      if (rise !== 6) begin
         n_fail++;
         $display("FAIL single_latency: valid rose after edge %0d, want 6", rise);
      end
      n_cmp++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL single_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_bounce();
      logic [2:0] seq[$];
      int twos = 0, rejs = 0;
      seq = '{3'b010, 3'b000, 3'b010, 3'b000};
      for (int i = 0; i < 8; i++) seq.push_back(3'b010);
      for (int i = 0; i < 10; i++) seq.push_back(3'b000);
      coin_rdy = 1'b1;
      foreach (seq[j]) begin
         coin_sense = seq[j];
         step();
         n_cmp++;
         if (w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL bounce_cycle%0d: got %b want %b", j, w_dut, exp_vec());
         end
         if (coin_valid && coin_out == 3'd2) twos++;
         if (coin_reject) rejs++;
      end
      n_cmp++;
      if (twos !== 1 || rejs !== 0) begin
         n_fail++;
         $display("FAIL bounce_count: coins %0d rejects %0d, want 1 and 0", twos, rejs);
      end
   endtask

   task automatic test_reject();
      int rejs = 0, vals = 0;
      coin_rdy = 1'b1;
      for (int i = 0; i < 18; i++) begin
         coin_sense = (i < 8) ? 3'b011 : 3'b000;
         step();
         n_cmp++;
         if (w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL reject_cycle%0d: got %b want %b", i, w_dut, exp_vec());
         end
         if (coin_reject) rejs++;
         if (coin_valid) vals++;
      end
      n_cmp++;
      if (rejs !== 1 || vals !== 0) begin
         n_fail++;
         $display("FAIL reject_count: rejects %0d valid cycles %0d, want 1 and 0", rejs, vals);
      end
   endtask

   task automatic test_fifo_full();
      int drops = 0;
      coin_rdy = 1'b0;
      for (int c = 0; c < 5; c++) begin
         for (int i = 0; i < 16; i++) begin
            coin_sense = (i < 8) ? 3'b001 : 3'b000;
            step();
            n_cmp++;
            if (w_dut !== exp_vec()) begin
               n_fail++;
               $display("FAIL full_fill%0d_%0d: got %b want %b", c, i, w_dut, exp_vec());
            end
            if (coin_drop) drops++;
         end
      end
      n_cmp++;
      if (fifo_count !== 3'd4 || drops !== 1) begin
         n_fail++;
         $display("FAIL full_state: count %0d drops %0d, want 4 and 1", fifo_count, drops);
      end
      coin_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (coin_valid !== 1'b1 || coin_out !== 3'd1) begin
            n_fail++;
            $display("FAIL full_pop%0d: valid %b out %0d, want 1 and 1", k, coin_valid, coin_out);
         end
         step();
      end
      n_cmp++;
      if (fifo_count !== 3'd0 || coin_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL full_drained: count %0d valid %b, want 0 and 0", fifo_count, coin_valid);
      end
   endtask

   task automatic test_push_pop_full();
      logic [2:0] pats[4];
      int expd[4];
      pats = '{3'b001, 3'b010, 3'b100, 3'b001};
      expd = '{2, 5, 1, 2};
      coin_rdy = 1'b0;
      foreach (pats[c]) begin
         for (int i = 0; i < 16; i++) begin
            coin_sense = (i < 8) ? pats[c] : 3'b000;
            step();
            n_cmp++;
            if (w_dut !== exp_vec()) begin
               n_fail++;
               $display("FAIL pp_fill%0d_%0d: got %b want %b", c, i, w_dut, exp_vec());
            end
         end
      end
      coin_sense = 3'b010;
      for (int i = 0; i < 5; i++) step();
      coin_rdy = 1'b1;
      step();
      coin_rdy = 1'b0;
      n_cmp++;
      if (fifo_count !== 3'd4 || coin_drop !== 1'b0 || w_dut !== exp_vec()) begin
         n_fail++;
         $display("FAIL pp_same_cycle: count %0d drop %b vec %b, want 4 0 %b",
                  fifo_count, coin_drop, w_dut, exp_vec());
      end
      for (int i = 0; i < 10; i++) begin
         coin_sense = (i < 2) ? 3'b010 : 3'b000;
         step();
      end
      coin_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (coin_out !== 3'(expd[k])) begin
            n_fail++;
            $display("FAIL pp_order%0d: got %0d want %0d", k, coin_out, expd[k]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      int vals = 0;
      coin_rdy = 1'b0; coin_sense = 3'b100;
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (w_dut !== 9'd0) begin
            n_fail++;
            $display("FAIL rstmid_during: got %b want %b", w_dut, 9'd0);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (coin_valid) vals++;
      end
      n_cmp++;
      if (vals !== 0) begin
         n_fail++;
         $display("FAIL rstmid_held: valid cycles %0d want 0", vals);
      end
      for (int i = 0; i < 24; i++) begin
         coin_sense = (i >= 8 && i < 16) ? 3'b100 : 3'b000;
         step();
         n_cmp++;
         if (w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL rstmid_cycle%0d: got %b want %b", i, w_dut, exp_vec());
         end
      end
      n_cmp++;
      if (fifo_count !== 3'd1 || coin_out !== 3'd5) begin
         n_fail++;
         $display("FAIL rstmid_reapply: count %0d out %0d, want 1 and 5", fifo_count, coin_out);
      end
      coin_rdy = 1'b1;
      step();
   endtask

   task automatic test_random();
      logic [2:0] seq[$];
      logic [2:0] pat;
      int r;
      for (int e = 0; e < 40; e++) begin
         r = $urandom_range(0, 9);
         if (r < 3) pat = 3'b001;
         else if (r < 6) pat = 3'b010;
         else if (r < 8) pat = 3'b100;
         else pat = 3'($urandom_range(1, 7));
         seq.delete();
         for (int b = $urandom_range(0, 3); b > 0; b--) begin
            seq.push_back(pat);
            seq.push_back(3'($urandom_range(0, 7)));
         end
         for (int h = $urandom_range(1, 7); h > 0; h--) seq.push_back(pat);
         for (int z = $urandom_range(1, 7); z > 0; z--) seq.push_back(3'b000);
         foreach (seq[j]) begin
            coin_sense = seq[j];
            coin_rdy   = ($urandom_range(0, 3) == 0);
            step();
            n_cmp++;
            if (w_dut !== exp_vec()) begin
               n_fail++;
               $display("FAIL random_e%0d_c%0d: got %b want %b", e, j, w_dut, exp_vec());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_bounce();
      test_reject();
      test_fifo_full();
      test_push_pop_full();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
